// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM state
// encoding and the load lane-select / extend helper.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  // Pick the addressed little-endian lane out of a memory word and
  // sign- or zero-extend it to 32 bits. Word size returns the word as-is.
  function automatic logic [31:0] lane_extend(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic        is_unsigned
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = is_unsigned ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = is_unsigned ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// Store merge for read-modify-write: replaces the addressed byte or
// halfword lane of the old memory word with the right-justified store data.
module lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  output logic [31:0] merged
);

  // Start from the old word and overwrite only the target lane(s)
  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{off, 3'b000} +: 8] = new_data[7:0];
      SZ_HALF: begin
        if (off[1]) begin
          merged[31:16] = new_data[15:0];
        end else begin
          merged[15:0] = new_data[15:0];
        end
      end
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM-stage pipeline register and a
// word-addressed data memory (combinational read, posedge write, whole
// words only). Loads and word stores complete with one-cycle latency from
// IDLE; byte/halfword stores take an extra RMW_WR cycle that writes the
// merged word, stalling the pipeline once.
// Optional feature: define MEM_ACCESS_ALIGN_CHECK_EN to report misaligned
// halfword/word accesses as errors; otherwise the low address bits are
// ignored for those sizes.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       dm_address,
  output logic              dm_w_enable,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] MEM_WORDS_IDX = IDX_W'(MEM_WORDS);

  state_t      state_q, state_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] rmw_addr_q, rmw_addr_d;
  logic [31:0] rmw_old_q, rmw_old_d;
  logic [1:0]  rmw_size_q, rmw_size_d;
  logic [1:0]  rmw_off_q, rmw_off_d;
  logic [15:0] rmw_wdata_q, rmw_wdata_d;

  logic [IDX_W-1:0] word_idx;
  logic [31:0]      idle_word_addr;
  logic [1:0]       eff_off;
  logic             misaligned;
  logic             out_of_range;
  logic             size_rsvd;
  logic             req_err;
  logic             accept;
  logic             word_store_now;
  logic [31:0]      merged_word;

  assign word_idx       = req_addr[ADDR_W-1:2];
  assign idle_word_addr = 32'({word_idx, 2'b00});
  assign out_of_range   = (word_idx >= MEM_WORDS_IDX);
  assign size_rsvd      = (req_size == SZ_RSVD);
  assign req_err        = size_rsvd | out_of_range | misaligned;
  assign req_ready      = (state_q == IDLE);
  assign accept         = req_valid & req_ready;
  assign stall          = req_valid & ~req_ready;
  assign word_store_now = accept & req_write & ~req_err & (req_size == SZ_WORD);

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  // Effective lane offset and misalignment decode for the incoming request
  always_comb begin
    eff_off = req_addr[1:0];
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
    if (req_size == SZ_HALF) begin
      eff_off = {req_addr[1], 1'b0};
    end else if (req_size == SZ_WORD) begin
      eff_off = 2'b00;
    end
`endif
  end

  lane_merge u_lane_merge (
    .old_word (rmw_old_q),
    .new_data ({16'h0000, rmw_wdata_q}),
    .size     (rmw_size_q),
    .off      (rmw_off_q),
    .merged   (merged_word)
  );

  // Memory-side drive: request address and data in IDLE, latched merge in
  // RMW_WR; write enable is held low while reset is asserted
  always_comb begin
    dm_address  = idle_word_addr;
    dm_wdata    = req_wdata;
    dm_w_enable = word_store_now;
    if (state_q == RMW_WR) begin
      dm_address  = rmw_addr_q;
      dm_wdata    = merged_word;
      dm_w_enable = 1'b1;
    end
    dm_w_enable = dm_w_enable & rst_n;
  end

  // Next-state, response and RMW-latch computation
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0000_0000;
    rmw_addr_d   = rmw_addr_q;
    rmw_old_d    = rmw_old_q;
    rmw_size_d   = rmw_size_q;
    rmw_off_d    = rmw_off_q;
    rmw_wdata_d  = rmw_wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_write) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = lane_extend(dm_rdata, req_size, eff_off, req_unsigned);
          end else if (req_size == SZ_WORD) begin
            resp_valid_d = 1'b1;
          end else begin
            state_d     = RMW_WR;
            rmw_addr_d  = idle_word_addr;
            rmw_old_d   = dm_rdata;
            rmw_size_d  = req_size;
            rmw_off_d   = eff_off;
            rmw_wdata_d = req_wdata[15:0];
          end
        end
      end
      RMW_WR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset abandons any pending RMW write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      rmw_addr_q   <= 32'h0000_0000;
      rmw_old_q    <= 32'h0000_0000;
      rmw_size_q   <= SZ_BYTE;
      rmw_off_q    <= 2'b00;
      rmw_wdata_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      rmw_addr_q   <= rmw_addr_d;
      rmw_old_q    <= rmw_old_d;
      rmw_size_q   <= rmw_size_d;
      rmw_off_q    <= rmw_off_d;
      rmw_wdata_q  <= rmw_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural data memory.
// Expected responses are queued when a request is driven and popped when
// the unit responds. Expectations follow MEM_ACCESS_ALIGN_CHECK_EN.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_address;
  logic        dm_w_enable;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
    int          lat;
    logic        rdy1;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        rdy1;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] mem [0:MEM_WORDS-1];
  int          wr_count = 0;
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = 6'd0;
  logic [31:0] bd_data = 32'h0;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dm_address   (dm_address),
    .dm_w_enable  (dm_w_enable),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural data memory with a backdoor port for preloading
  always @(posedge clk) begin
    if (dm_w_enable) begin
      wr_count <= wr_count + 1;
      if (dm_address[31:2] < 30'(MEM_WORDS)) mem[dm_address[7:2]] <= dm_wdata;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
  end

  assign dm_rdata = (dm_address[31:2] < 30'(MEM_WORDS)) ? mem[dm_address[7:2]] : 32'h0;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idle_req();
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = SZ_WORD;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
  endtask

  task automatic drive_vec(input vec_t v);
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_size     = v.sz;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wd;
    exp_q.push_back('{rdata: v.er, err: v.ee, lat: v.lat, rdy1: v.rdy1});
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_idx  = idx[5:0];
    bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  // Issue one request, then wait (bounded) for its response pulse
  task automatic run_one(input vec_t v, output bit got, output int lat, output logic rdy1);
    @(negedge clk);
    drive_vec(v);
    @(posedge clk);
    #1 idle_req();
    got  = 1'b0;
    lat  = 0;
    rdy1 = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) rdy1 = req_ready;
      if (resp_valid) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_req();
    repeat (2) @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = SZ_WORD;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
        resp_err !== 1'b0 || dm_w_enable !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: ready=%b valid=%b rdata=%h err=%b wen=%b stall=%b, required 1 0 00000000 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, dm_w_enable, stall);
    end
    idle_req();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_ext();
    vec_t v[$];
    exp_t e;
    bit got;
    int lat;
    logic rdy1;
    preload(0, 32'h8899AABB);
    v.push_back('{1'b0, SZ_BYTE, 1'b0, 32'h1, 32'h0, 32'hFFFFFFAA, 1'b0, 1, 1'b1});
    v.push_back('{1'b0, SZ_BYTE, 1'b1, 32'h1, 32'h0, 32'h000000AA, 1'b0, 1, 1'b1});
    v.push_back('{1'b0, SZ_BYTE, 1'b0, 32'h3, 32'h0, 32'hFFFFFF88, 1'b0, 1, 1'b1});
    v.push_back('{1'b0, SZ_BYTE, 1'b1, 32'h0, 32'h0, 32'h000000BB, 1'b0, 1, 1'b1});
    v.push_back('{1'b0, SZ_HALF, 1'b0, 32'h2, 32'h0, 32'hFFFF8899, 1'b0, 1, 1'b1});
    v.push_back('{1'b0, SZ_HALF, 1'b1, 32'h0, 32'h0, 32'h0000AABB, 1'b0, 1, 1'b1});
    v.push_back('{1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h8899AABB, 1'b0, 1, 1'b1});
    foreach (v[i]) begin
      run_one(v[i], got, lat, rdy1);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || lat != e.lat || rdy1 !== e.rdy1 || resp_rdata !== e.rdata || resp_err !== e.err) begin
        n_fail++;
        $display("[TB] FAIL load_ext[%0d]: valid=%0b lat=%0d rdy=%b rdata=%h err=%b, required lat=%0d rdy=%b rdata=%h err=%b",
                 i, got, lat, rdy1, resp_rdata, resp_err, e.lat, e.rdy1, e.rdata, e.err);
      end
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL resp_pulse_end: valid=%b rdata=%h, required 0 00000000", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_subword_store();
    vec_t v[$];
    exp_t e;
    bit got;
    int lat;
    logic rdy1;
    preload(0, 32'h11223344);
    preload(1, 32'h00000000);
    v.push_back('{1'b1, SZ_BYTE, 1'b0, 32'h2, 32'hFFFFFF55, 32'h0, 1'b0, 2, 1'b0});
    v.push_back('{1'b1, SZ_HALF, 1'b0, 32'h6, 32'h1234BEEF, 32'h0, 1'b0, 2, 1'b0});
    v.push_back('{1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0, 32'hFFFFBEEF, 1'b0, 1, 1'b1});
    v.push_back('{1'b0, SZ_BYTE, 1'b1, 32'h2, 32'h0, 32'h00000055, 1'b0, 1, 1'b1});
    foreach (v[i]) begin
      run_one(v[i], got, lat, rdy1);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || lat != e.lat || rdy1 !== e.rdy1 || resp_rdata !== e.rdata || resp_err !== e.err) begin
        n_fail++;
        $display("[TB] FAIL subword_store[%0d]: valid=%0b lat=%0d rdy=%b rdata=%h err=%b, required lat=%0d rdy=%b rdata=%h err=%b",
                 i, got, lat, rdy1, resp_rdata, resp_err, e.lat, e.rdy1, e.rdata, e.err);
      end
    end
    n_checks++;
    if (mem[0] !== 32'h11553344 || mem[1] !== 32'hBEEF0000) begin
      n_fail++;
      $display("[TB] FAIL subword_mem: word0=%h word1=%h, required 11553344 beef0000", mem[0], mem[1]);
    end
  endtask

  task automatic test_align();
    vec_t v[$];
    exp_t e;
    bit got;
    int lat;
    logic rdy1;
    int wr0;
    preload(2, 32'h00000000);
    wr0 = wr_count;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    v.push_back('{1'b1, SZ_WORD, 1'b0, 32'h0A, 32'hCAFEF00D, 32'h0, 1'b1, 1, 1'b1});
    v.push_back('{1'b0, SZ_HALF, 1'b1, 32'h07, 32'h0, 32'h0, 1'b1, 1, 1'b1});
    v.push_back('{1'b1, SZ_HALF, 1'b0, 32'h05, 32'h7777, 32'h0, 1'b1, 1, 1'b1});
`else
    v.push_back('{1'b1, SZ_WORD, 1'b0, 32'h0A, 32'hCAFEF00D, 32'h0, 1'b0, 1, 1'b1});
    v.push_back('{1'b0, SZ_HALF, 1'b1, 32'h07, 32'h0, 32'h0000BEEF, 1'b0, 1, 1'b1});
    v.push_back('{1'b1, SZ_HALF, 1'b0, 32'h05, 32'h7777, 32'h0, 1'b0, 2, 1'b0});
`endif
    foreach (v[i]) begin
      run_one(v[i], got, lat, rdy1);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || lat != e.lat || rdy1 !== e.rdy1 || resp_rdata !== e.rdata || resp_err !== e.err) begin
        n_fail++;
        $display("[TB] FAIL align[%0d]: valid=%0b lat=%0d rdy=%b rdata=%h err=%b, required lat=%0d rdy=%b rdata=%h err=%b",
                 i, got, lat, rdy1, resp_rdata, resp_err, e.lat, e.rdy1, e.rdata, e.err);
      end
    end
    n_checks++;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (mem[2] !== 32'h0 || mem[1] !== 32'hBEEF0000 || wr_count != wr0) begin
      n_fail++;
      $display("[TB] FAIL align_mem: word2=%h word1=%h writes=%0d, required 00000000 beef0000 0",
               mem[2], mem[1], wr_count - wr0);
    end
`else
    if (mem[2] !== 32'hCAFEF00D || mem[1] !== 32'hBEEF7777 || wr_count != wr0 + 2) begin
      n_fail++;
      $display("[TB] FAIL align_mem: word2=%h word1=%h writes=%0d, required cafef00d beef7777 2",
               mem[2], mem[1], wr_count - wr0);
    end
`endif
  endtask

  task automatic test_errors();
    vec_t v[$];
    exp_t e;
    bit got;
    int lat;
    logic rdy1;
    int wr0;
    wr0 = wr_count;
    v.push_back('{1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b1});
    v.push_back('{1'b0, SZ_BYTE, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 1'b1});
    v.push_back('{1'b0, SZ_RSVD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 1'b1});
    v.push_back('{1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1, 1, 1'b1});
    v.push_back('{1'b1, SZ_BYTE, 1'b0, 32'h104, 32'h11, 32'h0, 1'b1, 1, 1'b1});
    v.push_back('{1'b1, SZ_WORD, 1'b0, 32'hFC, 32'hA5A5_0F0F, 32'h0, 1'b0, 1, 1'b1});
    v.push_back('{1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0, 32'hA5A5_0F0F, 1'b0, 1, 1'b1});
    foreach (v[i]) begin
      run_one(v[i], got, lat, rdy1);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || lat != e.lat || rdy1 !== e.rdy1 || resp_rdata !== e.rdata || resp_err !== e.err) begin
        n_fail++;
        $display("[TB] FAIL errors[%0d]: valid=%0b lat=%0d rdy=%b rdata=%h err=%b, required lat=%0d rdy=%b rdata=%h err=%b",
                 i, got, lat, rdy1, resp_rdata, resp_err, e.lat, e.rdy1, e.rdata, e.err);
      end
    end
    n_checks++;
    if (wr_count != wr0 + 1) begin
      n_fail++;
      $display("[TB] FAIL error_no_write: writes=%0d, required 1", wr_count - wr0);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    exp_t e;
    v.push_back('{1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0BAD_F00D, 32'h0, 1'b0, 1, 1'b1});
    v.push_back('{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0BAD_F00D, 1'b0, 1, 1'b1});
    v.push_back('{1'b1, SZ_WORD, 1'b0, 32'h14, 32'h1357_9BDF, 32'h0, 1'b0, 1, 1'b1});
    v.push_back('{1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 32'h1357_9BDF, 1'b0, 1, 1'b1});
    v.push_back('{1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'h0000000B, 1'b0, 1, 1'b1});
    foreach (v[i]) begin
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (resp_valid !== 1'b1 || stall !== 1'b0 || resp_rdata !== e.rdata || resp_err !== e.err) begin
          n_fail++;
          $display("[TB] FAIL back_to_back[%0d]: valid=%b stall=%b rdata=%h err=%b, required 1 0 %h %b",
                   i - 1, resp_valid, stall, resp_rdata, resp_err, e.rdata, e.err);
        end
      end
      drive_vec(v[i]);
      @(posedge clk);
    end
    @(negedge clk);
    idle_req();
    e = exp_q.pop_front();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err) begin
      n_fail++;
      $display("[TB] FAIL back_to_back[last]: valid=%b rdata=%h err=%b, required 1 %h %b",
               resp_valid, resp_rdata, resp_err, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_during_rmw();
    preload(3, 32'h12345678);
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_size     = SZ_BYTE;
    req_unsigned = 1'b0;
    req_addr     = 32'h0D;
    req_wdata    = 32'hAA;
    @(posedge clk);
    #1 idle_req();
    @(negedge clk);
    n_checks++;
    if (dm_w_enable !== 1'b1 || req_ready !== 1'b0 || dm_address !== 32'h0C || dm_wdata !== 32'h1234AA78) begin
      n_fail++;
      $display("[TB] FAIL rmw_phase: wen=%b ready=%b addr=%h wdata=%h, required 1 0 0000000c 1234aa78",
               dm_w_enable, req_ready, dm_address, dm_wdata);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dm_w_enable !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rmw_reset_wen: wen=%b, required 0", dm_w_enable);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem[3] !== 32'h12345678) begin
        n_fail++;
        $display("[TB] FAIL rmw_reset_abandon[%0d]: valid=%b ready=%b word3=%h, required 0 1 12345678",
                 i, resp_valid, req_ready, mem[3]);
      end
    end
  endtask

  initial begin
    idle_req();
    test_reset();
    test_load_ext();
    test_subword_store();
    test_align();
    test_errors();
    test_back_to_back();
    test_reset_during_rmw();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
